// File: rtl/alu_mdu_ctrl.sv
// alu_mdu_ctrl -- ALU control decoder plus an iterative multiply/divide unit.
//
// The ALU control code is decoded combinationally from ALUOp_i and the
// funct7/funct3 fields of instr_i. M-extension ops (ALUOp=10, funct7=0000001)
// are executed by a sequential MDU: one shift-add (MUL) or restoring-subtract
// (DIV/REM) step per cycle, XLEN steps, then a one-cycle valid_o pulse.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   valid_i    instruction/operands present this cycle
//   instr_i    instruction word (funct7=[31:25], funct3=[14:12])
//   ALUOp_i    main-decoder class (00 ld/st, 01 branch, 10 R-type, 11 I-type)
//   rs1_i      operand 1, sampled when an MDU op is accepted
//   rs2_i      operand 2, sampled when an MDU op is accepted
//   ALUCtrl_o  combinational ALU operation code
//   ready_o    high when a new MDU op can be accepted (IDLE)
//   stall_o    pipeline hold request while an MDU op is being started/run
//   valid_o    one-cycle pulse, result_o valid
//   result_o   registered MDU result, held until the next completion
module alu_mdu_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [31:0]     instr_i,
  input  logic [1:0]      ALUOp_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [3:0]      ALUCtrl_o,
  output logic            ready_o,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MDU  = 4'b1010;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       is_mdu;
  logic       unused_bits;

  assign funct7 = instr_i[31:25];
  assign funct3 = instr_i[14:12];
  assign is_mdu = (ALUOp_i == 2'b10) && (funct7 == 7'b0000001);
  // Register-address and opcode fields play no part in this block.
  assign unused_bits = ^{instr_i[24:15], instr_i[11:0]};

  // Base RV32I funct3 map; sra_sel picks SRA over SRL for funct3=101.
  function automatic logic [3:0] base_op(input logic [2:0] f3, input logic sra_sel);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = sra_sel ? OP_SRA : OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

  always_comb begin
    ALUCtrl_o = OP_ADD;
    case (ALUOp_i)
      2'b00: ALUCtrl_o = OP_ADD;
      2'b01: ALUCtrl_o = OP_SUB;
      2'b10: begin
        if (funct7 == 7'b0000001) begin
          ALUCtrl_o = OP_MDU;
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      ALUCtrl_o = OP_SUB;
          else if (funct3 == 3'b101) ALUCtrl_o = OP_SRA;
          else                       ALUCtrl_o = OP_ADD;
        end else if (funct7 == 7'b0000000) begin
          ALUCtrl_o = base_op(funct3, 1'b0);
        end else begin
          ALUCtrl_o = OP_ADD;
        end
      end
      default: ALUCtrl_o = base_op(funct3, instr_i[30]);
    endcase
  end

  // ---------------------------------------------------------------------
  // MDU
  // ---------------------------------------------------------------------
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0]  a_reg;      // multiplicand (MUL) or divisor magnitude (DIV)
  logic [XLEN-1:0]  b_reg;      // multiplier (MUL) or dividend -> quotient (DIV)
  logic [XLEN-1:0]  acc_reg;    // product (MUL) or partial remainder (DIV)
  logic             op_div_reg;
  logic             op_rem_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;

  // Operand preparation at acceptance.
  logic            signed_div;
  logic            s1_neg;
  logic            s2_neg;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;

  assign signed_div = funct3[2] & ~funct3[0];
  assign s1_neg     = signed_div & rs1_i[XLEN-1];
  assign s2_neg     = signed_div & rs2_i[XLEN-1];
  // The most-negative value has no positive twin, but its bit pattern is the
  // correct unsigned magnitude, so plain negation is fine here.
  assign mag1       = s1_neg ? -rs1_i : rs1_i;
  assign mag2       = s2_neg ? -rs2_i : rs2_i;
  assign div_zero   = funct3[2] && (rs2_i == '0);
  assign div_ovf    = signed_div && (rs1_i == MOST_NEG) && (rs2_i == '1);

  // One iteration step.
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   rem_diff;
  logic            div_ge;
  logic [XLEN-1:0] acc_step;
  logic [XLEN-1:0] a_step;
  logic [XLEN-1:0] b_step;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] final_res;

  always_comb begin
    rem_shift = {acc_reg, b_reg[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, a_reg};
    div_ge    = ~rem_diff[XLEN];
    if (op_div_reg) begin
      acc_step = div_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
      a_step   = a_reg;
      b_step   = {b_reg[XLEN-2:0], div_ge};
    end else begin
      acc_step = acc_reg + (b_reg[0] ? a_reg : '0);
      a_step   = {a_reg[XLEN-2:0], 1'b0};
      b_step   = {1'b0, b_reg[XLEN-1:1]};
    end
    quo_fix = neg_q_reg ? -b_step : b_step;
    rem_fix = neg_r_reg ? -acc_step : acc_step;
    if (!op_div_reg)     final_res = acc_step;
    else if (op_rem_reg) final_res = rem_fix;
    else                 final_res = quo_fix;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      op_div_reg <= 1'b0;
      op_rem_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_o   <= '0;
      valid_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (valid_i && is_mdu) begin
            op_div_reg <= funct3[2];
            op_rem_reg <= funct3[1];
            neg_q_reg  <= s1_neg ^ s2_neg;
            neg_r_reg  <= s1_neg;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            if (div_zero) begin
              // Early exit: no iterations needed.
              result_o  <= funct3[1] ? rs1_i : '1;
              valid_o   <= 1'b1;
              state_reg <= S_DONE;
            end else if (div_ovf) begin
              result_o  <= funct3[1] ? '0 : rs1_i;
              valid_o   <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              a_reg     <= funct3[2] ? mag2 : rs1_i;
              b_reg     <= funct3[2] ? mag1 : rs2_i;
              state_reg <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          a_reg   <= a_step;
          b_reg   <= b_step;
          acc_reg <= acc_step;
          if (cnt_reg == LAST_STEP) begin
            result_o  <= final_res;
            valid_o   <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_DONE: state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign ready_o = (state_reg == S_IDLE);
  assign stall_o = ((state_reg == S_IDLE) && valid_i && is_mdu) || (state_reg == S_BUSY);

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
module tb_alu_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [1:0]  alu_op;

  logic        valid32;
  logic [31:0] rs1_32, rs2_32;
  logic [3:0]  alu_ctrl32;
  logic        ready32, stall32, vout32;
  logic [31:0] result32;

  logic        valid16;
  logic [15:0] rs1_16, rs2_16;
  logic [3:0]  alu_ctrl16;
  logic        ready16, stall16, vout16;
  logic [15:0] result16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_mdu_ctrl #(.XLEN(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid32), .instr_i(instr), .ALUOp_i(alu_op),
    .rs1_i(rs1_32), .rs2_i(rs2_32), .ALUCtrl_o(alu_ctrl32), .ready_o(ready32),
    .stall_o(stall32), .valid_o(vout32), .result_o(result32)
  );

  alu_mdu_ctrl #(.XLEN(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid16), .instr_i(instr), .ALUOp_i(alu_op),
    .rs1_i(rs1_16), .rs2_i(rs2_16), .ALUCtrl_o(alu_ctrl16), .ready_o(ready16),
    .stall_o(stall16), .valid_o(vout16), .result_o(result16)
  );

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 10'd0, f3, 5'd0, 7'b0110011};
  endfunction

  // Drives one MDU op starting at a negedge and measures its behaviour.
  // lat = cycle offset of the valid_o pulse (-1 on timeout).
  task automatic do_mdu_op(input bit use16, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input bit hold_busy,
                           output int lat, output logic [31:0] res,
                           output bit stall_t, output int stall_low, output bit pulse_ok);
    lat = -1; res = '0; stall_low = 0; pulse_ok = 1'b0;
    instr  = mk(7'b0000001, f3);
    alu_op = 2'b10;
    if (use16) begin valid16 = 1'b1; rs1_16 = a[15:0]; rs2_16 = b[15:0]; end
    else       begin valid32 = 1'b1; rs1_32 = a;       rs2_32 = b;       end
    #1;
    stall_t = use16 ? (stall16 && ready16) : (stall32 && ready32);
    @(posedge clk); #1;
    rs1_32 = ~a; rs2_32 = 32'h5A5A_1234; rs1_16 = ~a[15:0]; rs2_16 = 16'h1234;
    if (hold_busy) instr = mk(7'b0000001, 3'b100);
    else begin valid32 = 1'b0; valid16 = 1'b0; end
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 5) begin valid32 = 1'b0; valid16 = 1'b0; end
      if (use16 ? vout16 : vout32) begin
        lat = k;
        res = use16 ? {16'h0, result16} : result32;
        break;
      end else if (!(use16 ? stall16 : stall32)) begin
        stall_low++;
      end
    end
    @(negedge clk);
    pulse_ok = use16 ? (!vout16 && ready16) : (!vout32 && ready32);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({ready32, stall32, vout32, result32} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_state: rdy/stall/vld/res=%b/%b/%b/%h required 1/0/0/00000000",
               ready32, stall32, vout32, result32);
    end
    $display("reset_state: rdy=%b stall=%b vld=%b res=%h", ready32, stall32, vout32, result32);
  endtask

  task automatic test_decode();
    logic [1:0] ops [13] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10,
                             2'b11, 2'b10, 2'b10, 2'b10};
    logic [6:0] f7s [13] = '{7'h20, 7'h20, 7'h01, 7'h00, 7'h00, 7'h01, 7'h00, 7'h00, 7'h20,
                             7'h20, 7'h00, 7'h02, 7'h00};
    logic [2:0] f3s [13] = '{3'd0, 3'd5, 3'd7, 3'd0, 3'd7, 3'd6, 3'd2, 3'd5, 3'd1,
                             3'd0, 3'd3, 3'd0, 3'd5};
    logic [3:0] exps[13] = '{4'h1, 4'h7, 4'h0, 4'h1, 4'h2, 4'hA, 4'h8, 4'h6, 4'h0,
                             4'h0, 4'h9, 4'h0, 4'h6};
    for (int i = 0; i < 13; i++) begin
      alu_op = ops[i];
      instr  = mk(f7s[i], f3s[i]);
      #1;
      n_cmp++;
      if (alu_ctrl32 !== exps[i] || alu_ctrl16 !== exps[i]) begin
        n_bad++;
        $display("FAIL decode_%0d: ALUCtrl=%h/%h required %h", i, alu_ctrl32, alu_ctrl16, exps[i]);
      end
      $display("decode_%0d: aluop=%b f7=%h f3=%0d ctrl=%h", i, ops[i], f7s[i], f3s[i], alu_ctrl32);
    end
    @(negedge clk);
  endtask

  task automatic check_op(input string name, input bit use16, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input bit hold_busy,
                          input int exp_lat, input logic [31:0] exp_res);
    int lat; logic [31:0] res; bit stall_t; int stall_low; bit pulse_ok;
    do_mdu_op(use16, f3, a, b, hold_busy, lat, res, stall_t, stall_low, pulse_ok);
    n_cmp++;
    if (lat != exp_lat || res !== exp_res || !stall_t || stall_low != 0 || !pulse_ok) begin
      n_bad++;
      $display("FAIL %s: lat=%0d res=%h stallT=%b stall_low=%0d pulse_ok=%b required lat=%0d res=%h stallT=1 stall_low=0 pulse_ok=1",
               name, lat, res, stall_t, stall_low, pulse_ok, exp_lat, exp_res);
    end
    $display("%s: a=%h b=%h lat=%0d res=%h", name, a, b, lat, res);
  endtask

  task automatic test_mul();
    check_op("mul_7x-3",   1'b0, 3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0, 33, 32'hFFFF_FFEB);
    check_op("mulh_as_mul", 1'b0, 3'b001, 32'd6, 32'd7, 1'b0, 33, 32'd42);
    check_op("mul_shift",  1'b0, 3'b011, 32'h1234_5678, 32'h10, 1'b0, 33, 32'h2345_6780);
  endtask

  task automatic test_non_mdu();
    valid32 = 1'b1; alu_op = 2'b10; instr = mk(7'h00, 3'b000);
    rs1_32 = 32'h1111_1111; rs2_32 = 32'h2222_2222;
    #1;
    n_cmp++;
    if (stall32 !== 1'b0) begin
      n_bad++; $display("FAIL non_mdu_stall: stall=%b required 0", stall32);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (vout32 !== 1'b0 || ready32 !== 1'b1 || result32 !== 32'h2345_6780) begin
        n_bad++;
        $display("FAIL non_mdu_hold: vld=%b rdy=%b res=%h required 0/1/23456780", vout32, ready32, result32);
      end
    end
    valid32 = 1'b0;
    $display("non_mdu: vld=%b rdy=%b res=%h", vout32, ready32, result32);
  endtask

  task automatic test_div();
    check_op("div_-7/2",   1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0, 33, 32'hFFFF_FFFD);
    check_op("rem_-7/2",   1'b0, 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0, 33, 32'hFFFF_FFFF);
    check_op("divu_100/7", 1'b0, 3'b101, 32'd100, 32'd7, 1'b0, 33, 32'd14);
    check_op("remu_100/7", 1'b0, 3'b111, 32'd100, 32'd7, 1'b0, 33, 32'd2);
    check_op("div_7/-2",   1'b0, 3'b100, 32'd7, 32'hFFFF_FFFE, 1'b0, 33, 32'hFFFF_FFFD);
    check_op("rem_7/-2",   1'b0, 3'b110, 32'd7, 32'hFFFF_FFFE, 1'b0, 33, 32'd1);
    check_op("divu_max/1", 1'b0, 3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0, 33, 32'hFFFF_FFFF);
  endtask

  task automatic test_div_edge();
    check_op("divu_by0",  1'b0, 3'b101, 32'd5, 32'd0, 1'b0, 1, 32'hFFFF_FFFF);
    check_op("rem_ovf",   1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1, 32'd0);
    check_op("div_ovf",   1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1, 32'h8000_0000);
    check_op("div_-9by0", 1'b0, 3'b100, 32'hFFFF_FFF7, 32'd0, 1'b0, 1, 32'hFFFF_FFFF);
    check_op("rem_by0",   1'b0, 3'b110, 32'd5, 32'd0, 1'b0, 1, 32'd5);
  endtask

  task automatic test_busy_ignore();
    // valid_i stays high with a different op and new operands during BUSY.
    check_op("mul_busy_ignore", 1'b0, 3'b000, 32'd3, 32'd5, 1'b1, 33, 32'd15);
  endtask

  task automatic test_reset_mid();
    instr = mk(7'b0000001, 3'b100); alu_op = 2'b10;
    valid32 = 1'b1; rs1_32 = 32'hFFFF_FFF9; rs2_32 = 32'd2;
    @(posedge clk); #1;
    valid32 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ready32, stall32, vout32, result32} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_mid: rdy/stall/vld/res=%b/%b/%b/%h required 1/0/0/00000000",
               ready32, stall32, vout32, result32);
    end
    $display("reset_mid: rdy=%b stall=%b vld=%b res=%h", ready32, stall32, vout32, result32);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_op("div_after_reset", 1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0, 33, 32'hFFFF_FFFD);
  endtask

  task automatic test_xlen16();
    check_op("mul16_7x-3",   1'b1, 3'b000, 32'd7, 32'h0000_FFFD, 1'b0, 17, 32'h0000_FFEB);
    check_op("divu16_100/7", 1'b1, 3'b101, 32'd100, 32'd7, 1'b0, 17, 32'd14);
  endtask

  initial begin
    rst = 1'b1; valid32 = 1'b0; valid16 = 1'b0; instr = '0; alu_op = 2'b00;
    rs1_32 = '0; rs2_32 = '0; rs1_16 = '0; rs2_16 = '0;
    repeat (3) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_mul();          // first op accepted on the first edge after release
    test_non_mdu();
    test_decode();
    test_div();
    test_div_edge();
    test_busy_ignore();
    test_reset_mid();
    test_xlen16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
